// File: rtl/ooo_run_monitor_if.sv
// Commit-record bus and trace-drain port of the run monitor.
//   commit_v_i / commit_rob_tag_i / commit_new_i / commit_old_i : per-lane commit records (lane i at [i*W +: W])
//   trace_valid_o / trace_data_o / trace_ready_i                : FWFT trace FIFO drain handshake
// master = core/bench side, slave = monitor side.
interface ooo_run_monitor_if #(
    parameter int unsigned COMMIT_W = 2,
    parameter int unsigned TAG_W    = 6,
    parameter int unsigned PREG_W   = 7
);
    localparam int unsigned REC_W = TAG_W + 2 * PREG_W;

    logic [COMMIT_W-1:0]        commit_v_i;
    logic [COMMIT_W*TAG_W-1:0]  commit_rob_tag_i;
    logic [COMMIT_W*PREG_W-1:0] commit_new_i;
    logic [COMMIT_W*PREG_W-1:0] commit_old_i;
    logic                       trace_valid_o;
    logic [REC_W-1:0]           trace_data_o;
    logic                       trace_ready_i;

    modport master (
        output commit_v_i, commit_rob_tag_i, commit_new_i, commit_old_i, trace_ready_i,
        input  trace_valid_o, trace_data_o
    );

    modport slave (
        input  commit_v_i, commit_rob_tag_i, commit_new_i, commit_old_i, trace_ready_i,
        output trace_valid_o, trace_data_o
    );
endinterface

// File: rtl/ooo_run_monitor.sv
// Run monitor: counts dispatch/issue/commit events while a run is active, stops the
// run on a commit target or a cycle limit, and buffers commit records in a FWFT trace FIFO.
//   clk, rst_n          : clock, async active-low reset
//   start_i             : arm/restart a run (highest priority)
//   max_cycles_i        : cycle limit, 0 = unlimited
//   commit_target_i     : commit target, 0 = none
//   disp_fire_i         : dispatch fired this cycle
//   issue_v_i           : per-port issue valid
//   mon_bus             : commit record lanes in, trace FIFO drain out
//   state_o, done_o     : 0 IDLE / 1 RUN / 2 DONE_TARGET / 3 DONE_TIMEOUT, done flag
//   *_cnt_o             : saturating event counters
//   drop_cnt_o          : dropped trace records (saturating)
//   trace_overflow_o    : sticky drop flag
module ooo_run_monitor #(
    parameter int unsigned COMMIT_W    = 2,
    parameter int unsigned ISSUE_W     = 3,
    parameter int unsigned TAG_W       = 6,
    parameter int unsigned PREG_W      = 7,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TRACE_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [CNT_W-1:0]    max_cycles_i,
    input  logic [CNT_W-1:0]    commit_target_i,
    input  logic                disp_fire_i,
    input  logic [ISSUE_W-1:0]  issue_v_i,
    ooo_run_monitor_if.slave    mon_bus,
    output logic [1:0]          state_o,
    output logic                done_o,
    output logic [CNT_W-1:0]    cycle_cnt_o,
    output logic [CNT_W-1:0]    disp_cnt_o,
    output logic [CNT_W-1:0]    issue_cnt_o,
    output logic [CNT_W-1:0]    commit_cnt_o,
    output logic [15:0]         drop_cnt_o,
    output logic                trace_overflow_o
);
    localparam int unsigned PTR_W = $clog2(TRACE_DEPTH);
    localparam int unsigned CTR_W = PTR_W + 1;
    localparam int unsigned REC_W = TAG_W + 2 * PREG_W;
    localparam int unsigned DRP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_DONE_TGT  = 2'd2,
        ST_DONE_TO   = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_done;
    logic [CNT_W-1:0]   r_cycle_cnt, r_disp_cnt, r_issue_cnt, r_commit_cnt;
    logic [DRP_W-1:0]   r_drop_cnt;
    logic               r_overflow;
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CTR_W-1:0]   r_count;
    logic               r_valid;
    logic [REC_W-1:0]   r_mem [TRACE_DEPTH];

    logic               w_run;
    logic               w_pop;
    logic [CNT_W-1:0]   w_issue_pop, w_commit_pop;
    logic [CNT_W-1:0]   w_cycle_nx, w_disp_nx, w_issue_nx, w_commit_nx;
    logic               w_hit_tgt, w_hit_max;
    logic [CTR_W-1:0]   w_free, w_n_push, w_n_drop, w_count_nx;
    logic [DRP_W:0]     w_drop_sum;
    logic [DRP_W-1:0]   w_drop_nx;
    logic [COMMIT_W-1:0] w_wr_en;
    logic [PTR_W-1:0]   w_wr_idx [COMMIT_W];
    logic [REC_W-1:0]   w_rec    [COMMIT_W];

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Events only count in RUN, and never in a start cycle.
    assign w_run = (r_state == ST_RUN) && !start_i;
    assign w_pop = r_valid && mon_bus.trace_ready_i;

    // Popcounts and saturating next-counter values.
    always_comb begin
        w_issue_pop  = '0;
        w_commit_pop = '0;
        for (int i = 0; i < int'(ISSUE_W); i++)
            w_issue_pop = w_issue_pop + CNT_W'(issue_v_i[i]);
        for (int i = 0; i < int'(COMMIT_W); i++)
            w_commit_pop = w_commit_pop + CNT_W'(mon_bus.commit_v_i[i]);
    end

    assign w_cycle_nx  = sat_add(r_cycle_cnt, CNT_W'(1));
    assign w_disp_nx   = sat_add(r_disp_cnt, CNT_W'(disp_fire_i));
    assign w_issue_nx  = sat_add(r_issue_cnt, w_issue_pop);
    assign w_commit_nx = sat_add(r_commit_cnt, w_commit_pop);
    assign w_hit_tgt   = (commit_target_i != '0) && (w_commit_nx >= commit_target_i);
    assign w_hit_max   = (max_cycles_i != '0) && (w_cycle_nx >= max_cycles_i);

    // Lane packing: valid lanes go to consecutive slots in lane order until the
    // space free at cycle start runs out; a same-cycle pop does not help.
    always_comb begin
        w_free   = CTR_W'(TRACE_DEPTH) - r_count;
        w_n_push = '0;
        w_n_drop = '0;
        w_wr_en  = '0;
        for (int i = 0; i < int'(COMMIT_W); i++) begin
            w_wr_idx[i] = '0;
            w_rec[i]    = {mon_bus.commit_rob_tag_i[i*TAG_W +: TAG_W],
                           mon_bus.commit_new_i[i*PREG_W +: PREG_W],
                           mon_bus.commit_old_i[i*PREG_W +: PREG_W]};
            if (w_run && mon_bus.commit_v_i[i]) begin
                if (w_n_push < w_free) begin
                    w_wr_en[i]  = 1'b1;
                    w_wr_idx[i] = r_wr_ptr + PTR_W'(w_n_push);
                    w_n_push    = w_n_push + CTR_W'(1);
                end else begin
                    w_n_drop    = w_n_drop + CTR_W'(1);
                end
            end
        end
    end

    assign w_count_nx = r_count + w_n_push - CTR_W'(w_pop);
    assign w_drop_sum = {1'b0, r_drop_cnt} + (DRP_W+1)'(w_n_drop);
    assign w_drop_nx  = w_drop_sum[DRP_W] ? '1 : w_drop_sum[DRP_W-1:0];

    // Run control, counters and FIFO bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_done       <= 1'b0;
            r_cycle_cnt  <= '0;
            r_disp_cnt   <= '0;
            r_issue_cnt  <= '0;
            r_commit_cnt <= '0;
            r_drop_cnt   <= '0;
            r_overflow   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_valid      <= 1'b0;
        end else if (start_i) begin
            r_state      <= ST_RUN;
            r_done       <= 1'b0;
            r_cycle_cnt  <= '0;
            r_disp_cnt   <= '0;
            r_issue_cnt  <= '0;
            r_commit_cnt <= '0;
            r_drop_cnt   <= '0;
            r_overflow   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_valid      <= 1'b0;
        end else begin
            if (w_run) begin
                r_cycle_cnt  <= w_cycle_nx;
                r_disp_cnt   <= w_disp_nx;
                r_issue_cnt  <= w_issue_nx;
                r_commit_cnt <= w_commit_nx;
                if (w_n_drop != '0) begin
                    r_drop_cnt <= w_drop_nx;
                    r_overflow <= 1'b1;
                end
                if (w_hit_tgt) begin
                    r_state <= ST_DONE_TGT;
                    r_done  <= 1'b1;
                end else if (w_hit_max) begin
                    r_state <= ST_DONE_TO;
                    r_done  <= 1'b1;
                end
            end
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_push);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= w_count_nx;
            r_valid  <= (w_count_nx != '0);
        end
    end

    // Trace storage; contents are only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(COMMIT_W); i++)
            if (w_wr_en[i])
                r_mem[w_wr_idx[i]] <= w_rec[i];
    end

    assign mon_bus.trace_valid_o = r_valid;
    assign mon_bus.trace_data_o  = r_valid ? r_mem[r_rd_ptr] : '0;

    assign state_o          = r_state;
    assign done_o           = r_done;
    assign cycle_cnt_o      = r_cycle_cnt;
    assign disp_cnt_o       = r_disp_cnt;
    assign issue_cnt_o      = r_issue_cnt;
    assign commit_cnt_o     = r_commit_cnt;
    assign drop_cnt_o       = r_drop_cnt;
    assign trace_overflow_o = r_overflow;
endmodule
